mult_div_unit: RTL and testbench

- Iterative multiply/divide unit that sits directly downstream of the register file.
- Consumes the two register read ports (data_out_1 -> operand_a, data_out_2 -> operand_b) and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Holds the architectural HI/LO registers; EX stalls on busy and reads HI/LO for MFHI/MFLO.
- Radix-2 shift-add / restoring-divide datapath, one iteration per clock.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_iter_step.sv | 39 +++
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings, FSM state type and iteration count for the multiply/divide unit.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam int MD_ITERATIONS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } md_state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } md_mode_t;

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add multiply on {acc, multiplier} or restoring
// divide on {remainder, quotient}. Purely combinational, shared by both modes.
module md_iter_step
    import md_pkg::*;
#(
    parameter int DATA_WIDTH = MD_ITERATIONS
) (
    input  logic [2*DATA_WIDTH-1:0] work,
    input  logic [DATA_WIDTH-1:0]   operand,
    input  md_mode_t                mode,
    output logic [2*DATA_WIDTH-1:0] work_next
);

    localparam int W = DATA_WIDTH;

    logic [W:0]   mul_sum;
    logic [W:0]   rem_shift;
    logic [W:0]   div_diff;
    logic         div_borrow;
    logic         diff_top_unused;

    always_comb begin
        mul_sum         = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, operand} : {(W+1){1'b0}});
        // The shifted remainder needs W+1 bits; after a successful subtract it fits in W.
        rem_shift       = work[2*W-1:W-1];
        div_borrow      = rem_shift < {1'b0, operand};
        div_diff        = rem_shift - {1'b0, operand};
        diff_top_unused = div_diff[W];

        if (mode == MODE_MUL) begin
            work_next = {mul_sum, work[W-1:1]};
        end else if (!div_borrow) begin
            work_next = {div_diff[W-1:0], work[W-2:0], 1'b1};
        end else begin
            work_next = {work[2*W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers; one radix-2 step
// per clock, 33 clocks from start to result.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write HI/LO directly
// MUL   | shift-add iterations on {acc, multiplier}
// DIV   | restoring-divide iterations on {remainder, quotient}
// FIN   | sign fix-up, HI/LO write, done pulse follows
module mult_div_unit
    import md_pkg::*;
#(
    parameter int DATA_WIDTH = MD_ITERATIONS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    md_state_t            state, state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0]       work, work_step, prod_fix;
    logic [W-1:0]         operand_r, raw_a, hi_r, lo_r, quo_fix, rem_fix;
    logic [W-1:0]         a_mag, b_mag;
    logic                 is_div, neg_q, neg_r, div_zero, done_r;
    logic                 accept, is_signed, a_neg, b_neg, last_iter;

    md_iter_step #(.DATA_WIDTH(W)) u_step (
        .work      (work),
        .operand   (operand_r),
        .mode      ((state == DIV) ? MODE_DIV : MODE_MUL),
        .work_next (work_step)
    );

    always_comb begin
        accept    = (state == IDLE) && start && !cancel;
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = is_signed && operand_a[W-1];
        b_neg     = is_signed && operand_b[W-1];
        // Two's-complement negate of the most negative value yields its unsigned magnitude.
        a_mag     = a_neg ? -operand_a : operand_a;
        b_mag     = b_neg ? -operand_b : operand_b;
        last_iter = (cnt == CNT_WIDTH'(W - 1));
        prod_fix  = neg_q ? -work : work;
        quo_fix   = neg_q ? -work[W-1:0] : work[W-1:0];
        rem_fix   = neg_r ? -work[2*W-1:W] : work[2*W-1:W];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !op[2]) begin
                    state_next = op[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            work      <= '0;
            operand_r <= '0;
            raw_a     <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !op[2]) begin
                        cnt       <= '0;
                        is_div    <= op[1];
                        neg_q     <= a_neg ^ b_neg;
                        neg_r     <= a_neg;
                        div_zero  <= (operand_b == '0);
                        raw_a     <= operand_a;
                        operand_r <= op[1] ? b_mag : a_mag;
                        work      <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
                    end else if (accept && op == MD_MTHI) begin
                        hi_r <= operand_a;
                    end else if (accept && op == MD_MTLO) begin
                        lo_r <= operand_a;
                    end
                end
                MUL, DIV: begin
                    work <= work_step;
                    cnt  <= cnt + 1'b1;
                end
                FIN: begin
                    if (!cancel) begin
                        done_r <= 1'b1;
                        if (!is_div) begin
                            hi_r <= prod_fix[2*W-1:W];
                            lo_r <= prod_fix[W-1:0];
                        end else if (div_zero) begin
                            hi_r <= raw_a;
                            lo_r <= {W{1'b1}};
                        end else begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = done_r;
    assign hi_out = hi_r;
    assign lo_out = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and done
// edge; a negedge monitor pops on every done pulse and compares.
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                chk("result_hi", hi_out, e.hi);
                chk("result_lo", lo_out, e.lo);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge (E0).
    task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eh, input logic [31:0] el);
        int n;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        sb.push_back('{hi: eh, lo: el, cyc: cyc + 1 + 33});
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("busy_cycles", 32'(n), 32'd33);
    endtask

    initial begin : stim
        logic [31:0] hold_hi, hold_lo;

        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        run_arith(MD_MULT,  32'hFFFFFFE2, 32'h00000038, 32'hFFFFFFFF, 32'hFFFFF970);
        run_arith(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_arith(MD_DIV,   32'h00000038, 32'hFFFFFFE2, 32'h0000001A, 32'hFFFFFFFF);
        run_arith(MD_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        run_arith(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_arith(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_arith(MD_DIV,   32'hFFFFFF00, 32'h00000000, 32'hFFFFFF00, 32'hFFFFFFFF);
        run_arith(MD_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000);
        run_arith(MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);

        // MTHI then MTLO on consecutive edges
        start = 1'b1; op = MD_MTHI; operand_a = 32'hDEADBEEF; operand_b = '0;
        @(negedge clock);
        chk("mthi_hi", hi_out, 32'hDEADBEEF);
        chk("mthi_lo_held", lo_out, 32'd14);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        op = MD_MTLO; operand_a = 32'h0BADF00D;
        @(negedge clock);
        start = 1'b0;
        chk("mtlo_lo", lo_out, 32'h0BADF00D);
        chk("mtlo_hi_held", hi_out, 32'hDEADBEEF);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);

        // cancel coincident with start drops it
        start = 1'b1; cancel = 1'b1; op = MD_MTHI; operand_a = 32'h11111111;
        @(negedge clock);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_mthi_hi", hi_out, 32'hDEADBEEF);
        start = 1'b1; cancel = 1'b1; op = MD_MULT; operand_a = 32'd2; operand_b = 32'd2;
        @(negedge clock);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_mult_busy", {31'b0, busy}, 32'd0);

        // start while busy is ignored; operands are not re-sampled
        start = 1'b1; op = MD_MULT; operand_a = 32'd7; operand_b = 32'hFFFFFFFD;
        sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB, cyc: cyc + 1 + 33});
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        start = 1'b1; op = MD_MULTU; operand_a = 32'd2; operand_b = 32'd2;
        @(negedge clock);
        start = 1'b0;
        repeat (30) @(negedge clock);
        chk("busy_start_idle", {31'b0, busy}, 32'd0);

        // cancel mid-operation
        hold_hi = hi_out; hold_lo = lo_out;
        start = 1'b1; op = MD_MULT; operand_a = 32'd100; operand_b = 32'd100;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        start = 1'b1; op = MD_MULTU; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        chk("pre_cancel_busy", {31'b0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        chk("cancel_busy_e20", {31'b0, busy}, 32'd0);
        @(negedge clock);
        chk("cancel_busy_e21", {31'b0, busy}, 32'd0);
        repeat (20) @(negedge clock);
        chk("cancel_hi_held", hi_out, hold_hi);
        chk("cancel_lo_held", lo_out, hold_lo);
        chk("cancel_busy_late", {31'b0, busy}, 32'd0);

        // asynchronous reset mid-divide
        start = 1'b1; op = MD_DIVU; operand_a = 32'hCAFEF00D; operand_b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_done", {31'b0, done}, 32'd0);
        chk("async_rst_hi", hi_out, 32'd0);
        chk("async_rst_lo", lo_out, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_arith(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
